// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable synchronous instruction memory:
// FSM state encoding, the default NOP word and the fetch-address fault check.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // A fetch faults when it is not word aligned or lies beyond the 2**addr_bits words.
    function automatic logic addr_fault(input logic [31:0] byte_addr, input int addr_bits);
        logic [31:0] upper;
        upper = byte_addr >> (addr_bits + 2);
        return (byte_addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/imem_sync_loadable_if.sv
// Fetch, response and program-load signals of the instruction memory.
// The master modport is the CPU/loader side, the slave modport the memory.
interface imem_sync_loadable_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  FetchValid;
    logic                  FetchReady;
    logic [31:0]           FetchAddr;
    logic                  RspValid;
    logic                  RspReady;
    logic [DATA_WIDTH-1:0] RspInstr;
    logic                  RspFault;
    logic                  LoadEn;
    logic                  LoadValid;
    logic                  LoadReady;
    logic [DATA_WIDTH-1:0] LoadData;
    logic                  Busy;

    modport master (
        output FetchValid, FetchAddr, RspReady, LoadEn, LoadValid, LoadData,
        input  FetchReady, RspValid, RspInstr, RspFault, LoadReady, Busy
    );

    modport slave (
        input  FetchValid, FetchAddr, RspReady, LoadEn, LoadValid, LoadData,
        output FetchReady, RspValid, RspInstr, RspFault, LoadReady, Busy
    );
endinterface

// File: rtl/imem_ram_sp.sv
// Single-port synchronous RAM with a registered read port. The read register only
// updates on a read enable, so the last word read stays on rdata while a consumer stalls.
module imem_ram_sp #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset branch so it maps onto block RAM; contents are
    // cleared by the owner's INIT sweep instead of by rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_sync_loadable.sv
// Clocked, loadable instruction memory: INIT clears the array, RUN serves fetches with
// 1-cycle latency, LOAD streams in a program. Optional IMEM_PARITY_EN adds a parity bit per word.
module imem_sync_loadable
    import imem_pkg::*;
#(
    parameter int                    ADDR_BITS  = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP)
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_sync_loadable_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);
`ifdef IMEM_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  addr_fault_q, addr_fault_d;

    logic                  fetch_accept;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0] ram_wword;
    logic [RAM_W-1:0]      ram_wdata;
    logic [RAM_W-1:0]      ram_rdata;
    logic                  rd_fault;
    logic                  rsp_fault;

    // NOTE: every signal driven here gets a default first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        rsp_valid_d    = rsp_valid_q;
        addr_fault_d   = addr_fault_q;
        bus.FetchReady = 1'b0;
        bus.LoadReady  = 1'b0;
        fetch_accept   = 1'b0;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_addr       = bus.FetchAddr[ADDR_BITS+1:2];
        ram_wword      = NOP_WORD;

        unique case (state_q)
            ST_INIT: begin
                ram_we   = 1'b1;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + ONE;
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.FetchReady = !bus.LoadEn && (!rsp_valid_q || bus.RspReady);
                fetch_accept   = bus.FetchValid && bus.FetchReady;
                ram_re         = fetch_accept;
                if (fetch_accept) begin
                    rsp_valid_d  = 1'b1;
                    addr_fault_d = addr_fault(bus.FetchAddr, ADDR_BITS);
                end else if (bus.RspReady) begin
                    rsp_valid_d = 1'b0;
                end
                // A pending response must drain before the array is handed to the loader.
                if (bus.LoadEn && !rsp_valid_q) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_LOAD: begin
                bus.LoadReady = bus.LoadEn;
                if (bus.LoadEn && bus.LoadValid) begin
                    ram_we    = 1'b1;
                    ram_addr  = ptr_q;
                    ram_wword = bus.LoadData;
                    ptr_d     = ptr_q + ONE;
                end
                if (!bus.LoadEn) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values computed before this edge, independent of process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            addr_fault_q <= addr_fault_d;
        end
    end

`ifdef IMEM_PARITY_EN
    // Even parity: the stored bit makes the total number of ones even.
    assign ram_wdata = {^ram_wword, ram_wword};
    assign rd_fault  = ram_rdata[DATA_WIDTH] != (^ram_rdata[DATA_WIDTH-1:0]);
`else
    assign ram_wdata = ram_wword;
    assign rd_fault  = 1'b0;
`endif

    imem_ram_sp #(
        .DEPTH (DEPTH),
        .WIDTH (RAM_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_fault    = rsp_valid_q && (addr_fault_q || rd_fault);
    assign bus.RspValid = rsp_valid_q;
    assign bus.RspFault = rsp_fault;
    assign bus.RspInstr = (rsp_valid_q && !rsp_fault) ? ram_rdata[DATA_WIDTH-1:0] : NOP_WORD;
    assign bus.Busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Self-checking bench for imem_sync_loadable (ADDR_BITS=3): directed scenarios plus
// randomized fetch/load traffic compared every cycle against a word-array reference model.
module tb_imem_sync_loadable;

    localparam int ADDR_BITS = 3;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    logic clk;
    logic reset;

    imem_sync_loadable_if #(.DATA_WIDTH(32)) bus ();

    imem_sync_loadable #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain word array plus the mode the memory must be in.
    typedef enum {M_INIT, M_RUN, M_LOAD} mode_e;
    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    mode_e       m_mode = M_INIT;
    int          m_init_left = DEPTH;
    int          m_ptr = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    bit          m_fault = 1'b0;
    bit          m_fready;
    bit          m_prev_valid;
    rsp_t        got_q[$];

    function automatic void model_fetch(input logic [31:0] a, output logic [31:0] ins, output bit flt);
        int idx;
        idx = int'((a / 4) % DEPTH);
        flt = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        ins = 32'h0;
        if (!flt) begin
            if (m_bad[idx]) flt = 1'b1;
            else            ins = m_mem[idx];
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_rsp_valid",  bus.RspValid,   0);
            check("rst_rsp_instr",  bus.RspInstr,   32'h0);
            check("rst_rsp_fault",  bus.RspFault,   0);
            check("rst_fetch_rdy",  bus.FetchReady, 0);
            check("rst_load_rdy",   bus.LoadReady,  0);
            check("rst_busy",       bus.Busy,       1);
            m_mode      = M_INIT;
            m_init_left = DEPTH;
            m_valid     = 1'b0;
            m_ptr       = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = 32'h0;
                m_bad[i] = 1'b0;
            end
        end else begin
            case (m_mode)
                M_INIT: begin
                    check("init_busy",      bus.Busy,       1);
                    check("init_fetch_rdy", bus.FetchReady, 0);
                    check("init_load_rdy",  bus.LoadReady,  0);
                    check("init_rsp_valid", bus.RspValid,   0);
                    m_init_left--;
                    if (m_init_left == 0) m_mode = M_RUN;
                end
                M_RUN: begin
                    m_fready = !bus.LoadEn && (!m_valid || bus.RspReady);
                    check("run_busy",      bus.Busy,       0);
                    check("run_load_rdy",  bus.LoadReady,  0);
                    check("run_fetch_rdy", bus.FetchReady, 32'(m_fready));
                    check("run_rsp_valid", bus.RspValid,   32'(m_valid));
                    if (m_valid) begin
                        check("run_rsp_instr", bus.RspInstr, m_instr);
                        check("run_rsp_fault", bus.RspFault, 32'(m_fault));
                        if (bus.RspReady) got_q.push_back('{bus.RspInstr, bus.RspFault});
                    end
                    m_prev_valid = m_valid;
                    if (bus.FetchValid && m_fready) begin
                        m_valid = 1'b1;
                        model_fetch(bus.FetchAddr, m_instr, m_fault);
                    end else if (bus.RspReady) begin
                        m_valid = 1'b0;
                    end
                    if (bus.LoadEn && !m_prev_valid) begin
                        m_mode = M_LOAD;
                        m_ptr  = 0;
                    end
                end
                M_LOAD: begin
                    check("load_busy",      bus.Busy,       1);
                    check("load_fetch_rdy", bus.FetchReady, 0);
                    check("load_load_rdy",  bus.LoadReady,  32'(bus.LoadEn));
                    check("load_rsp_valid", bus.RspValid,   0);
                    if (bus.LoadEn && bus.LoadValid) begin
                        m_mem[m_ptr] = bus.LoadData;
                        m_bad[m_ptr] = 1'b0;
                        m_ptr        = (m_ptr + 1) % DEPTH;
                    end
                    if (!bus.LoadEn) m_mode = M_RUN;
                end
                default: m_mode = M_INIT;
            endcase
        end
    end

    // Stimulus is applied 1 time unit after the rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.FetchValid = 1'b0;
        bus.LoadValid  = 1'b0;
        repeat (n) sync();
    endtask

    task automatic fetch(input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        bus.FetchValid = 1'b1;
        bus.FetchAddr  = addr;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.FetchReady) begin
                ok = 1'b1;
                break;
            end
        end
        check("fetch_accepted", 32'(ok), 1);
        sync();
        bus.FetchValid = 1'b0;
    endtask

    task automatic load_beat(input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        bus.LoadEn    = 1'b1;
        bus.LoadValid = 1'b1;
        bus.LoadData  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.LoadReady) begin
                ok = 1'b1;
                break;
            end
        end
        check("load_accepted", 32'(ok), 1);
        sync();
        bus.LoadValid = 1'b0;
    endtask

    task automatic end_load();
        bus.LoadEn    = 1'b0;
        bus.LoadValid = 1'b0;
        sync();
    endtask

    task automatic wait_run();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.Busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("init_finished", 32'(ok), 1);
        sync();
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] ins, input logic flt);
        rsp_t r;
        check({name, "_present"}, 32'(got_q.size() > 0), 1);
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            check({name, "_instr"}, r.instr, ins);
            check({name, "_fault"}, 32'(r.fault), 32'(flt));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, DEPTH - 1)) << 2;
            2:       return 32'($urandom_range(0, DEPTH * 4 - 1));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int busy_cycles;
        int burst;

        reset          = 1'b0;
        bus.FetchValid = 1'b0;
        bus.FetchAddr  = 32'h0;
        bus.RspReady   = 1'b1;
        bus.LoadEn     = 1'b0;
        bus.LoadValid  = 1'b0;
        bus.LoadData   = 32'h0;
        repeat (3) sync();
        reset = 1'b1;

        // 1: INIT lasts exactly DEPTH cycles, then a cleared word reads back as NOP.
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.Busy) break;
            busy_cycles++;
        end
        check("init_busy_cycles", 32'(busy_cycles), 32'(DEPTH));
        sync();
        got_q.delete();
        fetch(32'h14);
        idle(2);
        expect_rsp("t1_fetch14", 32'h0, 1'b0);

        // 2: load three words, fetch them back to back.
        load_beat(32'h2004_0003);
        load_beat(32'h0C00_0003);
        load_beat(32'h1000_FFFF);
        end_load();
        got_q.delete();
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        idle(3);
        expect_rsp("t2_w0", 32'h2004_0003, 1'b0);
        expect_rsp("t2_w1", 32'h0C00_0003, 1'b0);
        expect_rsp("t2_w2", 32'h1000_FFFF, 1'b0);

        // 3: stalled consumer holds the response and blocks new requests.
        got_q.delete();
        bus.RspReady = 1'b0;
        fetch(32'h0);
        bus.FetchValid = 1'b1;
        bus.FetchAddr  = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_fetch_rdy", bus.FetchReady, 0);
            check("t3_stall_instr",     bus.RspInstr,   32'h2004_0003);
        end
        sync();
        bus.RspReady = 1'b1;
        fetch(32'h4);
        fetch(32'h8);
        idle(3);
        expect_rsp("t3_r0", 32'h2004_0003, 1'b0);
        expect_rsp("t3_r1", 32'h0C00_0003, 1'b0);
        expect_rsp("t3_r2", 32'h1000_FFFF, 1'b0);

        // 4: misaligned and out-of-range faults, then a clean fetch.
        got_q.delete();
        fetch(32'h2);
        fetch(32'h40);
        fetch(32'h4);
        idle(3);
        expect_rsp("t4_misaligned", 32'h0, 1'b1);
        expect_rsp("t4_range",      32'h0, 1'b1);
        expect_rsp("t4_ok",         32'h0C00_0003, 1'b0);

        // 5: reset in the middle of a load re-runs the clear.
        load_beat(32'hAAAA_0001);
        load_beat(32'hAAAA_0002);
        reset = 1'b0;
        sync();
        bus.LoadEn = 1'b0;
        sync();
        reset = 1'b1;
        wait_run();
        got_q.delete();
        fetch(32'h0);
        fetch(32'h4);
        idle(3);
        expect_rsp("t5_w0_cleared", 32'h0, 1'b0);
        expect_rsp("t5_w1_cleared", 32'h0, 1'b0);

        // 6: nine beats wrap the load pointer onto word 0.
        for (int i = 1; i <= 9; i++) load_beat(32'(i));
        end_load();
        got_q.delete();
        fetch(32'h0);
        fetch(32'h4);
        idle(3);
        expect_rsp("t6_w0_wrapped", 32'h9, 1'b0);
        expect_rsp("t6_w1", 32'h2, 1'b0);
`ifdef IMEM_PARITY_EN
        dut.u_ram.mem_q[1] = dut.u_ram.mem_q[1] ^ 33'h1;
        m_bad[1] = 1'b1;
        got_q.delete();
        fetch(32'h4);
        idle(3);
        expect_rsp("t6_parity", 32'h0, 1'b1);
`endif

        // Randomized traffic with load bursts, stalls and one mid-run reset.
        burst = 0;
        for (int c = 0; c < 2500; c++) begin
            if (burst > 0) begin
                bus.LoadEn = 1'b1;
                burst--;
            end else begin
                bus.LoadEn = 1'b0;
                if ($urandom_range(0, 40) == 0) burst = $urandom_range(1, 14);
            end
            bus.LoadValid  = 1'($urandom_range(0, 1));
            bus.LoadData   = $urandom;
            bus.FetchValid = 1'($urandom_range(0, 1));
            bus.FetchAddr  = rand_addr();
            bus.RspReady   = ($urandom_range(0, 3) != 0);
            if (c == 1200) reset = 1'b0;
            if (c == 1203) reset = 1'b1;
            sync();
        end
        bus.LoadEn   = 1'b0;
        bus.RspReady = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_sync_loadable.md
Name: imem_sync_loadable

Overview:
- Parametrised, clocked instruction memory for the multi-cycle and pipelined CPU generations.
- Replaces the hard-wired combinational program ROM.
- Provides a writable word array, cleared after reset.
- Programs are loaded through a streaming load port.
- Fetch requests are served through a valid/ready handshake with 1-cycle latency; misaligned and out-of-range fetch addresses are flagged as faults.

Parameters:
ADDR_BITS, 8, word-address width; DEPTH = 2**ADDR_BITS words (default 256 words, byte range 0x000-0x3FF)
DATA_WIDTH, 32, instruction word width
NOP_WORD, 32'h00000000, value returned on fault and written during clear

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
FetchValid  input  1  fetch request valid
FetchReady  output  1  fetch request accepted this cycle when both high
FetchAddr  input  32  byte address of instruction
RspValid  output  1  response valid
RspReady  input  1  consumer accepts response
RspInstr  output  DATA_WIDTH  fetched instruction
RspFault  output  1  response is a fault (address, or parity with option)
LoadEn  input  1  request/hold load mode
LoadValid  input  1  load beat valid
LoadReady  output  1  load beat accepted when both high
LoadData  input  DATA_WIDTH  load word
Busy  output  1  high in INIT and LOAD

Behaviour:
- States:
  - INIT: clears memory.
  - RUN: serves fetches.
  - LOAD: accepts program beats.
- Reset (reset=0):
  - state=INIT, clear counter=0, load pointer=0.
  - RspValid=0, RspInstr=NOP_WORD, RspFault=0.
  - FetchReady=0, LoadReady=0, Busy=1.
  - Memory contents are not reset directly.
- INIT:
  - Each cycle writes NOP_WORD to word[cnt], then cnt++.
  - After DEPTH cycles, goes to RUN; Busy falls on the first RUN cycle.
  - LoadEn and FetchValid are ignored during INIT.
- RUN:
  - FetchReady = !LoadEn && (!RspValid || RspReady).
  - An accepted request produces RspValid=1 on the next edge.
  - RspInstr = word[FetchAddr[ADDR_BITS+1:2]].
  - Fault condition: FetchAddr[1:0]!=0 or FetchAddr[31:ADDR_BITS+2]!=0. On fault, RspInstr=NOP_WORD and RspFault=1; otherwise RspFault=0.
  - Back-to-back accepts sustain one response per cycle.
  - While RspValid && !RspReady, RspInstr and RspFault hold stable and no new request is accepted.
  - RspValid clears when consumed with no new accept in the same cycle.
- RUN->LOAD:
  - Taken when LoadEn=1 and RspValid=0 (any pending response drains first).
  - Load pointer resets to 0 on entry.
- LOAD:
  - LoadReady=1 and FetchReady=0.
  - Each LoadValid beat writes word[ptr]=LoadData, then ptr++.
  - ptr wraps from DEPTH-1 to 0; later beats overwrite earlier ones.
  - When LoadEn falls, the state becomes RUN next cycle. A beat presented in that same cycle is not accepted (LoadReady goes low with LoadEn).
  - A word written in cycle N is fetchable by a request accepted in cycle N+2 or later.
- Reset asserted mid-LOAD or mid-fetch:
  - Aborts immediately.
  - Any pending response is dropped.
  - INIT re-runs and clears the whole array.
- Memory is single-ported: INIT/LOAD writes and RUN reads are mutually exclusive by state.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on every write (INIT and LOAD).
  - A read with mismatched parity returns RspInstr=NOP_WORD, RspFault=1.
  - Address faults behave unchanged.
- Undefined:
  - No parity storage; faults come from address checks only.
  - Port list identical in both builds.

Decomposition:
- Package imem_pkg:
  - State enum {ST_INIT, ST_RUN, ST_LOAD}.
  - NOP constant.
  - Address-fault helper function (alignment and range check).
- Sub-module imem_ram_sp:
  - Single-port synchronous RAM, parametrised depth and width.
  - 1-cycle registered read with read-enable hold, so output stays stable under stall.
  - Width is DATA_WIDTH+1 when IMEM_PARITY_EN is defined.
- Top level contains the FSM, clear counter, load pointer, handshake and fault logic.

Test Plan:
1. ADDR_BITS=3, release reset -> Busy=1, FetchReady=0 for exactly 8 cycles. Then fetch 0x14 -> RspValid next cycle, RspInstr=0x00000000, RspFault=0.
2. Load beats 0x20040003, 0x0C000003, 0x1000FFFF, drop LoadEn. Fetch 0x0, 0x4, 0x8 on consecutive cycles -> three responses on consecutive cycles, in order, with those values.
3. After test 2, hold RspReady=0 for 3 cycles with FetchValid=1 -> RspInstr stays 0x20040003 and FetchReady=0. Release -> remaining responses drain one per cycle.
4. Fetch 0x2 -> RspFault=1, RspInstr=0. Fetch 0x40 (ADDR_BITS=3) -> RspFault=1. Next fetch 0x4 -> RspFault=0.
5. Assert reset after 2 load beats, then release -> INIT re-runs. Fetch 0x0 after INIT -> 0x00000000.
6. ADDR_BITS=3, load 9 beats 0x1..0x9 -> word0=0x9, word1=0x2. With IMEM_PARITY_EN defined, force-flip stored bit 0 of word1 -> fetch 0x4 returns RspFault=1, RspInstr=0.
